// File: rtl/tdc_readout_arbiter_if.sv
// Valid/ready word stream carrying a TDC result word and its valid-data number.
interface tdc_readout_arbiter_if #(
    parameter int DATA_W = 19,
    parameter int NUM_W  = 3
);
    logic              valid;
    logic              ready;
    logic [DATA_W-1:0] data;
    logic [NUM_W-1:0]  num;

    modport master (output valid, data, num, input ready);
    modport slave  (input valid, data, num, output ready);
endinterface

// File: rtl/tdc_readout_arbiter.sv
// Two-channel TDC readout arbiter: per-channel FIFOs, round-robin output register.
// Optional saturating drop counters: define TDC_ARB_DROP_CNT_EN.
module tdc_readout_arbiter #(
    parameter int DATA_W = 19,
    parameter int NUM_W  = 3,
    parameter int DEPTH  = 4,
    parameter int DROP_W = 8
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  enable,
    tdc_readout_arbiter_if.slave  tdc1,
    tdc_readout_arbiter_if.slave  tdc2,
    tdc_readout_arbiter_if.master out,
    output logic                  out_ch,
    output logic                  int1,
    output logic                  int2,
    output logic                  busy,
    output logic [DROP_W-1:0]     drop1_cnt,
    output logic [DROP_W-1:0]     drop2_cnt
);
    localparam int AW = $clog2(DEPTH);
    localparam int W  = DATA_W + NUM_W;

    typedef enum logic [1:0] {IDLE, RUN, DRAIN} state_e;

    state_e         state_q;
    logic [W-1:0]   mem_q [2][DEPTH];
    logic [AW-1:0]  wp_q [2];
    logic [AW-1:0]  rp_q [2];
    logic [AW:0]    cnt_q [2];
    logic [W-1:0]   in_w [2];
    logic [W-1:0]   word_q;
    logic [1:0]     vld, full, ne, push, pop, int_q;
    logic           grant, load, prio_q, ov_q, ch_q;

    always_comb begin
        vld     = {tdc2.valid, tdc1.valid};
        in_w[0] = {tdc1.data, tdc1.num};
        in_w[1] = {tdc2.data, tdc2.num};
        for (int i = 0; i < 2; i++) begin
            full[i] = (cnt_q[i] == (AW+1)'(DEPTH));
            ne[i]   = (cnt_q[i] != '0);
            push[i] = (state_q == RUN) && vld[i] && !full[i];
        end
        load   = (!ov_q || out.ready) && (|ne);
        // prio_q names the channel that wins the next contention
        grant  = (ne[0] && ne[1]) ? prio_q : ne[1];
        pop[0] = load && !grant;
        pop[1] = load && grant;
    end

    assign tdc1.ready = (state_q == RUN) && !full[0];
    assign tdc2.ready = (state_q == RUN) && !full[1];
    assign out.valid  = ov_q;
    assign out.data   = word_q[W-1:NUM_W];
    assign out.num    = word_q[NUM_W-1:0];
    assign out_ch     = ch_q;
    assign int1       = int_q[0];
    assign int2       = int_q[1];
    assign busy       = (state_q != IDLE);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= IDLE;
            word_q  <= '0;
            ov_q    <= 1'b0;
            ch_q    <= 1'b0;
            prio_q  <= 1'b0;
            int_q   <= '0;
            for (int i = 0; i < 2; i++) begin
                wp_q[i]  <= '0;
                rp_q[i]  <= '0;
                cnt_q[i] <= '0;
                for (int j = 0; j < DEPTH; j++)
                    mem_q[i][j] <= '0;
            end
        end else begin
            for (int i = 0; i < 2; i++) begin
                if (push[i]) begin
                    mem_q[i][wp_q[i]] <= in_w[i];
                    wp_q[i] <= wp_q[i] + AW'(1);
                end
                if (pop[i])
                    rp_q[i] <= rp_q[i] + AW'(1);
                cnt_q[i] <= cnt_q[i] + (AW+1)'(push[i])
                                     - (AW+1)'(pop[i]);
                int_q[i] <= ne[i];
            end
            if (load) begin
                word_q <= mem_q[grant][rp_q[grant]];
                ov_q   <= 1'b1;
                ch_q   <= grant;
                prio_q <= ~grant;
            end else if (out.ready) begin
                ov_q <= 1'b0;
            end
            unique case (state_q)
                IDLE:  if (enable) state_q <= RUN;
                RUN:   if (!enable) state_q <= DRAIN;
                DRAIN: begin
                    if (enable)
                        state_q <= RUN;
                    else if (!(|ne) && !ov_q)
                        state_q <= IDLE;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

`ifdef TDC_ARB_DROP_CNT_EN
    logic [DROP_W-1:0] drop_q [2];
    logic [1:0]        drop;

    always_comb begin
        for (int i = 0; i < 2; i++)
            drop[i] = (state_q == RUN) && vld[i] && full[i];
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            drop_q[0] <= '0;
            drop_q[1] <= '0;
        end else begin
            for (int i = 0; i < 2; i++)
                if (drop[i] && !(&drop_q[i]))
                    drop_q[i] <= drop_q[i] + DROP_W'(1);
        end
    end

    assign drop1_cnt = drop_q[0];
    assign drop2_cnt = drop_q[1];
`else
    assign drop1_cnt = '0;
    assign drop2_cnt = '0;
`endif
endmodule

// File: tb/tb_tdc_readout_arbiter.sv
// Directed self-checking bench for tdc_readout_arbiter.
// Drop-count expectations follow TDC_ARB_DROP_CNT_EN.
module tb_tdc_readout_arbiter;
    localparam int DATA_W = 19;
    localparam int NUM_W  = 3;
    localparam int DROP_W = 8;
`ifdef TDC_ARB_DROP_CNT_EN
    localparam int DROP_ON = 1;
`else
    localparam int DROP_ON = 0;
`endif

    logic clk = 1'b0;
    logic rst_n, enable;
    logic out_ch, int1, int2, busy;
    logic [DROP_W-1:0] drop1_cnt, drop2_cnt;
    int n_chk = 0;
    int n_pass = 0;

    tdc_readout_arbiter_if #(.DATA_W(DATA_W), .NUM_W(NUM_W)) tdc1_if ();
    tdc_readout_arbiter_if #(.DATA_W(DATA_W), .NUM_W(NUM_W)) tdc2_if ();
    tdc_readout_arbiter_if #(.DATA_W(DATA_W), .NUM_W(NUM_W)) out_if ();

    tdc_readout_arbiter #(
        .DATA_W(DATA_W), .NUM_W(NUM_W), .DEPTH(4), .DROP_W(DROP_W)
    ) u_dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .enable    (enable),
        .tdc1      (tdc1_if.slave),
        .tdc2      (tdc2_if.slave),
        .out       (out_if.master),
        .out_ch    (out_ch),
        .int1      (int1),
        .int2      (int2),
        .busy      (busy),
        .drop1_cnt (drop1_cnt),
        .drop2_cnt (drop2_cnt)
    );

    always #2 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        enable = 1'b0;
        out_if.ready = 1'b0;
        tdc1_if.valid = 1'b0;
        tdc2_if.valid = 1'b0;
        step();
        rst_n = 1'b1;
    endtask

    initial begin
        tdc1_if.data = '0; tdc1_if.num = '0;
        tdc2_if.data = '0; tdc2_if.num = '0;
        do_reset();
        check("rst_ov", out_if.valid, 0);
        check("rst_int1", int1, 0);
        check("rst_int2", int2, 0);
        check("rst_busy", busy, 0);
        check("rst_rdy1", tdc1_if.ready, 0);
        check("rst_drop1", drop1_cnt, 0);

        // single word latency
        enable = 1'b1;
        step();
        check("run_busy", busy, 1);
        check("run_rdy1", tdc1_if.ready, 1);
        tdc1_if.valid = 1'b1;
        tdc1_if.data = 19'h1_2345;
        tdc1_if.num = 3'd3;
        step();
        tdc1_if.valid = 1'b0;
        check("sw_ov0", out_if.valid, 0);
        step();
        check("sw_ov1", out_if.valid, 1);
        check("sw_data", out_if.data, 32'h1_2345);
        check("sw_num", out_if.num, 3);
        check("sw_ch", out_ch, 0);
        check("sw_int1", int1, 1);
        out_if.ready = 1'b1;
        step();
        check("sw_ovclr", out_if.valid, 0);
        check("sw_int1lo", int1, 0);

        // contention: round robin, channel 1 first
        do_reset();
        enable = 1'b1;
        out_if.ready = 1'b1;
        step();
        for (int k = 0; k < 5; k++) begin
            tdc1_if.valid = (k < 4);
            tdc2_if.valid = (k < 4);
            tdc1_if.data = 19'h1000 + 19'(k);
            tdc2_if.data = 19'h2000 + 19'(k);
            step();
            if (k >= 1) begin
                check($sformatf("rr_ch%0d", k), out_ch, (k - 1) % 2);
                check($sformatf("rr_d%0d", k), out_if.data,
                      (((k - 1) % 2) ? 32'h2000 : 32'h1000) + (k - 1) / 2);
            end
        end
        tdc1_if.valid = 1'b0;
        tdc2_if.valid = 1'b0;

        // backpressure on channel 2
        do_reset();
        enable = 1'b1;
        step();
        for (int i = 0; i < 5; i++) begin
            tdc2_if.valid = 1'b1;
            tdc2_if.data = 19'h300 + 19'(i);
            step();
        end
        check("bp_rdy2", tdc2_if.ready, 0);
        check("bp_hold", out_if.data, 32'h300);
        check("bp_ch", out_ch, 1);
        tdc2_if.data = 19'h305;
        step();
        tdc2_if.valid = 1'b0;
        check("bp_drop2", drop2_cnt, DROP_ON);
        check("bp_hold2", out_if.data, 32'h300);
        check("bp_int2", int2, 1);

        // drain
        do_reset();
        enable = 1'b1;
        step();
        for (int i = 0; i < 3; i++) begin
            tdc1_if.valid = 1'b1;
            tdc1_if.data = 19'h40 + 19'(i);
            step();
        end
        tdc1_if.valid = 1'b0;
        check("dr_w0", out_if.data, 32'h40);
        enable = 1'b0;
        out_if.ready = 1'b1;
        step();
        tdc2_if.valid = 1'b1;
        tdc2_if.data = 19'h7f;
        check("dr_rdy1", tdc1_if.ready, 0);
        check("dr_rdy2", tdc2_if.ready, 0);
        check("dr_w1", out_if.data, 32'h41);
        check("dr_busy", busy, 1);
        step();
        check("dr_w2", out_if.data, 32'h42);
        check("dr_ov", out_if.valid, 1);
        step();
        check("dr_ovclr", out_if.valid, 0);
        check("dr_busy1", busy, 1);
        step();
        check("dr_idle", busy, 0);
        check("dr_int2", int2, 0);
        check("dr_drop2", drop2_cnt, 0);
        tdc2_if.valid = 1'b0;

        // drop counter saturation
        do_reset();
        enable = 1'b1;
        step();
        tdc1_if.valid = 1'b1;
        repeat (305) step();
        tdc1_if.valid = 1'b0;
        check("sat_rdy1", tdc1_if.ready, 0);
        check("sat_drop1", drop1_cnt, DROP_ON ? 255 : 0);

        // reset mid-stream
        do_reset();
        enable = 1'b1;
        step();
        tdc1_if.valid = 1'b1;
        tdc2_if.valid = 1'b1;
        repeat (2) step();
        tdc1_if.valid = 1'b0;
        tdc2_if.valid = 1'b0;
        check("mid_ov", out_if.valid, 1);
        rst_n = 1'b0;
        step();
        rst_n = 1'b1;
        check("mr_ov", out_if.valid, 0);
        check("mr_int1", int1, 0);
        check("mr_int2", int2, 0);
        check("mr_busy", busy, 0);
        check("mr_drop", {drop1_cnt, drop2_cnt}, 0);
        step();
        step();
        check("mr_empty", {out_if.valid, int1, int2}, 0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
